// File: rtl/ram_arbiter_pkg.sv
// ram_arbiter_pkg: FSM states, RAM command codes and default read timeout.
package ram_arbiter_pkg;
    typedef enum logic [2:0] {IDLE, SEND_ADDR, SEND_WDATA, SEND_RCMD, WAIT_RD, ACK} state_e;
    localparam logic [1:0] CMD_WADDR = 2'b00;
    localparam logic [1:0] CMD_WDATA = 2'b01;
    localparam logic [1:0] CMD_RADDR = 2'b10;
    localparam logic [1:0] CMD_READ  = 2'b11;
    localparam int DEFAULT_TIMEOUT = 15;
endpackage

// File: rtl/ram_arbiter_rr.sv
// rr_arbiter2: two-way round-robin grant with a one-bit priority pointer.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);
    logic ptr_q;
    assign grant = (req == 2'b11) ? (ptr_q ? 2'b10 : 2'b01) : req;
    // Pointer flips to the other requester when a grant is taken; it is only consulted in the next IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= 1'b0;
        else if (advance) ptr_q <= grant[0];
    end
endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: serves two requesters one at a time over a command-word RAM port,
// with round-robin arbitration and a bounded wait for read data.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int ADDR_SIZE = 8,
    parameter int TIMEOUT   = DEFAULT_TIMEOUT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           req,
    input  logic [1:0]           we,
    input  logic [ADDR_SIZE-1:0] addr0,
    input  logic [ADDR_SIZE-1:0] addr1,
    input  logic [ADDR_SIZE-1:0] wdata0,
    input  logic [ADDR_SIZE-1:0] wdata1,
    output logic [1:0]           ack,
    output logic [ADDR_SIZE-1:0] rdata,
    output logic                 err,
    output logic [ADDR_SIZE+1:0] ram_din,
    output logic                 ram_rx_valid,
    input  logic [ADDR_SIZE-1:0] ram_dout,
    input  logic                 ram_tx_valid
);
    localparam int CW = $clog2(TIMEOUT + 1);
    state_e               state_q, state_d;
    logic                 owner_q, owner_d, we_q, we_d, err_q, err_d, advance, sel;
    logic [ADDR_SIZE-1:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [1:0]           grant;

    rr_arbiter2 u_rr (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .advance (advance),
        .grant   (grant)
    );

    assign sel   = (grant == 2'b10);
    assign ack   = (state_q == ACK) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
    assign rdata = rdata_q;
    assign err   = err_q;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
        cnt_d        = cnt_q;
        advance      = 1'b0;
        ram_rx_valid = 1'b0;
        ram_din      = '0;
        case (state_q)
            IDLE: if (|req) begin
                advance = 1'b1;
                owner_d = sel;
                we_d    = sel ? we[1] : we[0];
                addr_d  = sel ? addr1 : addr0;
                wdata_d = sel ? wdata1 : wdata0;
                err_d   = 1'b0;
                state_d = SEND_ADDR;
            end
            SEND_ADDR: begin
                ram_rx_valid = 1'b1;
                ram_din      = {we_q ? CMD_WADDR : CMD_RADDR, addr_q};
                state_d      = we_q ? SEND_WDATA : SEND_RCMD;
            end
            SEND_WDATA: begin
                ram_rx_valid = 1'b1;
                ram_din      = {CMD_WDATA, wdata_q};
                state_d      = ACK;
            end
            SEND_RCMD: begin
                ram_rx_valid = 1'b1;
                ram_din      = {CMD_READ, {ADDR_SIZE{1'b0}}};
                cnt_d        = '0;
                state_d      = WAIT_RD;
            end
            WAIT_RD: if (ram_tx_valid) begin
                rdata_d = ram_dout;
                err_d   = 1'b0;
                state_d = ACK;
            end else begin
                // The cycle whose increment reaches TIMEOUT is the last WAIT_RD cycle.
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(TIMEOUT - 1)) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = ACK;
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: scoreboard bench; expected RAM commands and acks are queued when a
// request is driven and compared as the arbiter produces them.
module tb_ram_arbiter;
    localparam int TIMEOUT = 15;

    logic       clk = 1'b0, rst_n = 1'b0, err, ram_rx_valid, ram_tx_valid = 1'b0;
    logic [1:0] req = '0, we = '0, ack;
    logic [7:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0, rdata, ram_dout = '0;
    logic [9:0] ram_din;

    typedef struct {
        logic [1:0] ack;
        logic       rd;
        logic [7:0] rdata;
        logic       err;
        int         cyc;
    } exp_t;

    exp_t       sb[$];
    logic [9:0] cq[$];
    exp_t       em;
    int         cyc = 0, n_tests = 0, n_fail = 0;
    logic       ptr_m = 1'b0;

    ram_arbiter #(.ADDR_SIZE(8), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .we           (we),
        .addr0        (addr0),
        .addr1        (addr1),
        .wdata0       (wdata0),
        .wdata1       (wdata1),
        .ack          (ack),
        .rdata        (rdata),
        .err          (err),
        .ram_din      (ram_din),
        .ram_rx_valid (ram_rx_valid),
        .ram_dout     (ram_dout),
        .ram_tx_valid (ram_tx_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) if (rst_n) begin
        if (ram_rx_valid) begin
            if (cq.size() == 0) check("cmd_unexpected", cq.size(), 1);
            else check("ram_din", ram_din, cq.pop_front());
        end else check("ram_din_idle", ram_din, 0);
        if (ack != 2'b00) begin
            if (sb.size() == 0) check("ack_unexpected", sb.size(), 1);
            else begin
                em = sb.pop_front();
                check("ack", ack, em.ack);
                if (em.rd) check("rdata", rdata, em.rdata);
                check("err", err, em.err);
                check("ack_latency", cyc, em.cyc);
            end
        end
    end

    // Drive one request pattern and queue the n back-to-back transactions it must produce.
    task automatic issue(input logic [1:0] r, input logic [1:0] w, input logic [7:0] a0, input logic [7:0] a1,
                         input logic [7:0] d0, input logic [7:0] d1, input logic txv, input logic [7:0] dout,
                         input int n);
        int t, lat;
        logic o, wr;
        logic [7:0] a, d;
        req = r; we = w; addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1;
        ram_tx_valid = txv; ram_dout = dout;
        t = cyc;
        for (int i = 0; i < n; i++) begin
            o = (r == 2'b11) ? ptr_m : r[1];
            ptr_m = ~o;
            wr = w[o];
            a = o ? a1 : a0;
            d = o ? d1 : d0;
            lat = wr ? 3 : (txv ? 4 : 3 + TIMEOUT);
            sb.push_back('{ack: o ? 2'b10 : 2'b01, rd: !wr, rdata: txv ? dout : 8'h00,
                           err: !wr && !txv, cyc: t + lat});
            cq.push_back(wr ? {2'b00, a} : {2'b10, a});
            cq.push_back(wr ? {2'b01, d} : {2'b11, 8'h00});
            t += lat + 1;
        end
    endtask

    task automatic wait_done(input int budget);
        bit done = 0;
        for (int i = 0; i < budget && !done; i++) begin
            @(posedge clk);
            done = (sb.size() == 0);
        end
        if (!done) begin
            check("ack_wait_expired", sb.size(), 0);
            sb.delete();
            cq.delete();
        end
        #1 req = 2'b00;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", ack, 0);
        check("rst_err", err, 0);
        check("rst_rdata", rdata, 0);
        check("rst_rx_valid", ram_rx_valid, 0);
        check("rst_din", ram_din, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        issue(2'b01, 2'b01, 8'h12, 8'h00, 8'hAB, 8'h00, 1'b0, 8'h00, 1);
        wait_done(20);
        @(posedge clk); #1;
        issue(2'b10, 2'b00, 8'h00, 8'h12, 8'h00, 8'h00, 1'b1, 8'hAB, 1);
        wait_done(20);
        @(posedge clk); #1;
        check("rr_ptr_model_start", ptr_m, 0);
        issue(2'b11, 2'b11, 8'h21, 8'h42, 8'h31, 8'h52, 1'b1, 8'h00, 4);
        wait_done(40);
        @(posedge clk); #1;
        issue(2'b01, 2'b01, 8'h33, 8'h00, 8'h44, 8'h00, 1'b1, 8'h00, 1);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("arst_ack", ack, 0);
        check("arst_rx_valid", ram_rx_valid, 0);
        check("arst_din", ram_din, 0);
        check("arst_rdata", rdata, 0);
        check("arst_err", err, 0);
        sb.delete();
        cq.delete();
        req = 2'b00;
        ptr_m = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        issue(2'b01, 2'b01, 8'h66, 8'h00, 8'h77, 8'h00, 1'b0, 8'h00, 1);
        wait_done(20);
        @(posedge clk); #1;
        issue(2'b01, 2'b00, 8'h99, 8'h00, 8'h00, 8'h00, 1'b0, 8'h5A, 1);
        wait_done(60);
        @(posedge clk); #1;
        issue(2'b01, 2'b01, 8'h5A, 8'h00, 8'hC3, 8'h00, 1'b1, 8'h00, 1);
        @(posedge clk);
        #1 req = 2'b00;
        wait_done(20);
        repeat (10) @(posedge clk);
        check("sb_empty", sb.size(), 0);
        check("cq_empty", cq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter ADDR_SIZE, default 8: RAM address and data width.
REQ-002 Parameter TIMEOUT, default 15: maximum WAIT_RD cycles before an error completion.
REQ-003 clk  input  1: single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1: reset, asynchronous, active-low.
REQ-005 req  input  2: per-requester transaction request; bit i belongs to requester i.
REQ-006 we  input  2: per-requester operation; 1 = write, 0 = read.
REQ-007 addr0, addr1  input  ADDR_SIZE each: per-requester target address.
REQ-008 wdata0, wdata1  input  ADDR_SIZE each: per-requester write data.
REQ-009 ack  output  2: one-cycle completion pulse to the served requester.
REQ-010 rdata  output  ADDR_SIZE: read data, valid while ack is high for a read.
REQ-011 err  output  1: high with ack when a read timed out.
REQ-012 ram_din  output  ADDR_SIZE+2: command word to the RAM, {cmd[1:0], payload}.
REQ-013 ram_rx_valid  output  1: command strobe to the RAM.
REQ-014 ram_dout  input  ADDR_SIZE: RAM read data.
REQ-015 ram_tx_valid  input  1: RAM read-valid level; it is sticky, not a strobe.

Function
REQ-016 Commands SHALL be: 00 = set write address, 01 = write data, 10 = set read address, 11 = read.
REQ-017 The FSM SHALL have the states IDLE, SEND_ADDR, SEND_WDATA, SEND_RCMD, WAIT_RD and ACK; all outputs SHALL be registered or decoded from state only.
REQ-018 In IDLE, if any req bit is high, the block SHALL select an owner by round-robin. It SHALL latch that owner's we, addr and wdata, then go to SEND_ADDR.
REQ-019 Round-robin: a single requesting bit always wins. If both bits request, the priority pointer wins. After each ACK the pointer SHALL move to the non-served requester.
REQ-020 SEND_ADDR: ram_rx_valid=1 and ram_din={we?00:10, addr}. Next state is SEND_WDATA for a write, SEND_RCMD for a read.
REQ-021 SEND_WDATA: ram_rx_valid=1 and ram_din={01, wdata}. Next state is ACK.
REQ-022 SEND_RCMD: ram_rx_valid=1 and ram_din={11, all-zero payload}. Next state is WAIT_RD and the timeout counter clears.
REQ-023 WAIT_RD: ram_rx_valid=0. If ram_tx_valid=1, the block SHALL capture ram_dout into rdata and go to ACK with err=0.
REQ-024 WAIT_RD with ram_tx_valid=0: the counter SHALL increment each cycle. When the counter equals TIMEOUT, the block SHALL go to ACK with err=1 and rdata=0.
REQ-025 ACK: ack[owner]=1 for exactly one cycle; rdata and err hold their values; next state is IDLE.
REQ-026 In every state other than SEND_*, ram_rx_valid SHALL be 0 and ram_din SHALL be all-zero.
REQ-027 Latency from the IDLE cycle that sees req to ack high: write = 3 cycles; read = 4 cycles when ram_tx_valid is already high.
REQ-028 A requester SHALL hold req, we, addr and wdata stable until ack. It SHALL deassert req on the edge ending the ack cycle; a req still high in the following IDLE is a new transaction.
REQ-029 If req drops mid-transaction, the block SHALL complete the latched transaction and still pulse ack.
REQ-030 The non-owner's req SHALL be ignored until IDLE; requests are never lost, only deferred.
REQ-031 At most one transaction SHALL be in flight; there is no pipelining.

Reset
REQ-032 On rst_n low, immediately and regardless of state: state=IDLE, ack=0, err=0, rdata=0, ram_rx_valid=0, ram_din=0, counter=0, pointer=requester 0, latched fields=0.
REQ-033 Reset mid-transaction SHALL abandon the transaction with no ack; the first cycle after release SHALL be IDLE.

Structure
REQ-034 Package ram_arbiter_pkg SHALL hold the state enumeration, the four command codes and the default TIMEOUT.
REQ-035 Round-robin selection and the pointer SHALL live in sub-module rr_arbiter2 (inputs req[1:0] and advance; outputs grant[1:0]).

Verification
REQ-036 After reset, req=01, we=1, addr0=0x12, wdata0=0xAB -> ram_din shows 0x012 then 0x1AB with ram_rx_valid high; ack=01 three cycles after req is seen.
REQ-037 req=10, we=0, addr1=0x12, ram_tx_valid=1, ram_dout=0xAB -> ram_din shows 0x212 then 0x300; ack=10 with rdata=0xAB, err=0, four cycles after req is seen.
REQ-038 req=11 held continuously -> grants alternate 0,1,0,1 starting with requester 0.
REQ-039 Read with ram_tx_valid held 0 -> err=1, rdata=0 and ack pulse after 15 WAIT_RD cycles.
REQ-040 rst_n low during SEND_WDATA -> outputs clear immediately with no ack; after release, req=01 is served from IDLE normally.
REQ-041 req dropped during SEND_ADDR -> transaction completes and ack still pulses once.
